// File: rtl/pipelined_barrel_shifter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipelined_barrel_shifter : streaming SLL/SRL/SRA/ROL/ROR, one stage per amount bit
// Revision: 1.0
// ---------------------------------------------------------------------------
module pipelined_barrel_shifter #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] IN,
  input  logic [SHW-1:0]   shift_amnt,
  input  logic [2:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] OUT,
  output logic             out_err
);

  localparam logic [2:0] c_SLL = 3'd0;
  localparam logic [2:0] c_SRL = 3'd1;
  localparam logic [2:0] c_SRA = 3'd2;
  localparam logic [2:0] c_ROL = 3'd3;
  localparam logic [2:0] c_ROR = 3'd4;

  // Index i is the input side of stage i; index SHW is the output of the last stage.
  logic [WIDTH-1:0] w_data  [SHW+1];
  logic             w_valid [SHW+1];
  logic             w_err   [SHW+1];
  logic             w_ready [SHW+1];
  logic [2:0]       w_mode  [SHW];
  logic [SHW-1:0]   w_amnt  [SHW];

  assign w_data[0]    = IN;
  assign w_valid[0]   = in_valid;
  assign w_err[0]     = (mode > c_ROR);
  assign w_mode[0]    = mode;
  assign w_amnt[0]    = shift_amnt;
  assign w_ready[SHW] = out_ready;

  assign in_ready  = w_ready[0];
  assign OUT       = w_data[SHW];
  assign out_err   = w_err[SHW];
  assign out_valid = w_valid[SHW];

  for (genvar i = 0; i < SHW; i++) begin : g_stage
    localparam int c_DIST = 2 ** i;

    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_err;

    always_comb begin
      w_shifted = w_data[i];
      if (w_amnt[i][i]) begin
        case (w_mode[i])
          c_SLL:   w_shifted = w_data[i] << c_DIST;
          c_SRL:   w_shifted = w_data[i] >> c_DIST;
          c_SRA:   w_shifted = $signed(w_data[i]) >>> c_DIST;
          c_ROL:   w_shifted = (w_data[i] << c_DIST) | (w_data[i] >> (WIDTH - c_DIST));
          c_ROR:   w_shifted = (w_data[i] >> c_DIST) | (w_data[i] << (WIDTH - c_DIST));
          default: w_shifted = w_data[i];
        endcase
      end
    end

    // A stage may take new data when it is empty or its occupant moves on.
    assign w_ready[i] = !w_valid[i+1] || w_ready[i+1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_data  <= '0;
        r_err   <= 1'b0;
      end else if (w_ready[i]) begin
        r_valid <= w_valid[i];
        r_data  <= w_shifted;
        r_err   <= w_err[i];
      end
    end

    assign w_valid[i+1] = r_valid;
    assign w_data[i+1]  = r_data;
    assign w_err[i+1]   = r_err;

    if (i < SHW - 1) begin : g_carry
      logic [2:0]     r_mode;
      logic [SHW-1:0] r_amnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_mode <= '0;
          r_amnt <= '0;
        end else if (w_ready[i]) begin
          r_mode <= w_mode[i];
          r_amnt <= w_amnt[i];
        end
      end

      assign w_mode[i+1] = r_mode;
      assign w_amnt[i+1] = r_amnt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_barrel_shifter.sv
`default_nettype none
// Scoreboard bench: 8-bit and 32-bit instances checked against a bitwise reference model.
module tb_pipelined_barrel_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_err;
  logic [7:0]  in_data, out_data;
  logic [2:0]  shamt, mode;
  logic        in_valid_w, in_ready_w, out_valid_w, out_ready_w, out_err_w;
  logic [31:0] in_data_w, out_data_w;
  logic [4:0]  shamt_w;
  logic [2:0]  mode_w;

  pipelined_barrel_shifter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .IN(in_data), .shift_amnt(shamt), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .OUT(out_data), .out_err(out_err)
  );

  pipelined_barrel_shifter #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .IN(in_data_w), .shift_amnt(shamt_w), .mode(mode_w), .out_valid(out_valid_w),
    .out_ready(out_ready_w), .OUT(out_data_w), .out_err(out_err_w)
  );

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          t;
    bit          lat;
  } exp_t;

  exp_t q8[$];
  exp_t q32[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   rnd_done;

  always @(posedge clk) cyc <= cyc + 1;

  // Output bit j is taken from whichever input bit the mode's rule names.
  function automatic logic [31:0] model(input logic [31:0] x, input int w, input int a,
                                        input logic [2:0] m);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < w; j++) begin
      case (m)
        3'd0:    r[j] = (j - a >= 0) ? x[j-a] : 1'b0;
        3'd1:    r[j] = (j + a < w) ? x[j+a] : 1'b0;
        3'd2:    r[j] = (j + a < w) ? x[j+a] : x[w-1];
        3'd3:    r[j] = x[(j - a + w) % w];
        3'd4:    r[j] = x[(j + a) % w];
        default: r[j] = x[j];
      endcase
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic send8(input logic [7:0] d, input int a, input logic [2:0] m, input bit lat);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; shamt = a[2:0]; mode = m;
    #1;
    while (!in_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send8_timeout: got in_ready=0 want 1");
      in_valid = 1'b0;
      return;
    end
    e.d = model({24'b0, d}, 8, a, m); e.e = (m > 3'd4); e.t = cyc; e.lat = lat;
    q8.push_back(e);
    @(posedge clk);
  endtask

  task automatic send32(input logic [31:0] d, input int a, input logic [2:0] m, input bit lat);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    in_valid_w = 1'b1; in_data_w = d; shamt_w = a[4:0]; mode_w = m;
    #1;
    while (!in_ready_w && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready_w) begin
      total++; bad++;
      $display("FAIL send32_timeout: got in_ready=0 want 1");
      in_valid_w = 1'b0;
      return;
    end
    e.d = model(d, 32, a, m); e.e = (m > 3'd4); e.t = cyc; e.lat = lat;
    q32.push_back(e);
    @(posedge clk);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q8.size() != 0 || q32.size() != 0) && n < 300) begin
      @(negedge clk); n++;
    end
    check(name, q8.size() + q32.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // 8-bit monitor: pops on every transfer out and checks holding during stalls.
  logic       hold8;
  logic [7:0] hold_d;
  logic       hold_e;
  initial begin
    exp_t e;
    hold8 = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (!rst_n) begin
        hold8 = 1'b0;
      end else begin
        if (hold8) check("stall_hold", {out_valid, out_err, out_data}, {1'b1, hold_e, hold_d});
        if (out_valid && out_ready) begin
          hold8 = 1'b0;
          if (q8.size() == 0) begin
            total++; bad++;
            $display("FAIL out8_unexpected: got %h with empty scoreboard", out_data);
          end else begin
            e = q8.pop_front();
            check("out8", {out_err, out_data}, {e.e, e.d[7:0]});
            if (e.lat) check("lat8", cyc, e.t + 3);
          end
        end else if (out_valid) begin
          hold8 = 1'b1; hold_d = out_data; hold_e = out_err;
        end else begin
          hold8 = 1'b0;
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (rst_n && out_valid_w && out_ready_w) begin
        if (q32.size() == 0) begin
          total++; bad++;
          $display("FAIL out32_unexpected: got %h with empty scoreboard", out_data_w);
        end else begin
          e = q32.pop_front();
          check("out32", {31'b0, out_err_w}, {31'b0, e.e});
          check("out32_data", out_data_w, e.d);
          if (e.lat) check("lat32", cyc, e.t + 5);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0; shamt = '0; mode = '0;
    in_valid_w = 1'b0; out_ready_w = 1'b1; in_data_w = '0; shamt_w = '0; mode_w = '0;
    rnd_done = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out_data, 0);
    check("rst_err", out_err, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid32", out_valid_w, 0);
    @(negedge clk) rst_n = 1'b1;

    for (int m = 0; m < 5; m++) send8(8'hD2, 3, m[2:0], 1'b1);
    @(negedge clk) in_valid = 1'b0;
    drain("drain_modes");

    for (int a = 0; a < 8; a++) send8(8'hD2, a, 3'd4, 1'b1);
    @(negedge clk) in_valid = 1'b0;
    drain("drain_ror");

    @(negedge clk) out_ready = 1'b0;
    for (int a = 0; a < 3; a++) send8(8'h01, a, 3'd0, 1'b0);
    @(negedge clk) in_valid = 1'b0;
    #1;
    check("full_in_ready", in_ready, 0);
    check("stall_out", {out_valid, out_data}, {1'b1, 8'h01});
    repeat (3) @(negedge clk);
    out_ready = 1'b1;
    for (int a = 3; a < 6; a++) send8(8'h01, a, 3'd0, 1'b0);
    @(negedge clk) in_valid = 1'b0;
    drain("drain_bp");

    send8(8'hD2, 5, 3'b110, 1'b1);
    send8(8'hD2, 5, 3'd0, 1'b1);
    @(negedge clk) in_valid = 1'b0;
    drain("drain_illegal");

    @(negedge clk) out_ready = 1'b0;
    for (int a = 1; a < 4; a++) send8(8'hA5, a, 3'd3, 1'b0);
    @(negedge clk) in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out", out_data, 0);
    check("midrst_in_ready", in_ready, 1);
    q8.delete();
    q32.delete();
    @(negedge clk) begin rst_n = 1'b1; out_ready = 1'b1; end
    repeat (6) @(negedge clk);
    #1;
    check("post_rst_idle", out_valid, 0);

    send32(32'h8000_0001, 31, 3'd2, 1'b1);
    send32(32'h8000_0001, 31, 3'd3, 1'b1);
    for (int k = 0; k < 20; k++)
      send32($urandom, $urandom_range(0, 31), 3'($urandom_range(0, 7)), 1'b1);
    @(negedge clk) in_valid_w = 1'b0;
    drain("drain_32");

    fork
      begin
        for (int k = 0; k < 200; k++)
          send8(8'($urandom), $urandom_range(0, 7), 3'($urandom_range(0, 7)), 1'b0);
        @(negedge clk) in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    @(negedge clk) out_ready = 1'b1;
    drain("drain_random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
